// File: rtl/core_pkg.sv
// Shared RV32I core definitions: ALU op encoding, opcode, writeback-select and branch funct3 constants.
package core_pkg;

  localparam int unsigned XLEN_DEF = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/stage_3_exe_mem_if.sv
// ID/EX inputs, WB feedback and EX/MEM outputs of the execute stage.
interface stage_3_exe_mem_if #(parameter int unsigned XLEN = 32);
  logic            stall;
  logic [XLEN-1:0] ImmOut_rg2, data_R1_rg2, data_R2_rg2, count_rg2;
  logic [3:0]      ALUSel_rg2;
  logic            ASel_rg2, BSel_rg2, RWBEn_rg2, MEMRW_rg2;
  logic [1:0]      WBSel_rg2;
  logic [2:0]      func_3_rg2;
  logic [4:0]      rd_rg2, rs1_rg2, rs2_rg2, opcode_rg2;
  logic [31:0]     instt2;
  logic [4:0]      wb_rd;
  logic            wb_we;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] alu_rg3, store_data_rg3, pc_plus4_rg3;
  logic [4:0]      rd_rg3;
  logic            RWBEn_rg3, MEMRW_rg3;
  logic [1:0]      WBSel_rg3;
  logic [2:0]      func_3_rg3;
  logic [31:0]     instt3;
  logic            valid_rg3;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output stall, ImmOut_rg2, data_R1_rg2, data_R2_rg2, count_rg2, ALUSel_rg2,
           ASel_rg2, BSel_rg2, RWBEn_rg2, MEMRW_rg2, WBSel_rg2, func_3_rg2,
           rd_rg2, rs1_rg2, rs2_rg2, opcode_rg2, instt2, wb_rd, wb_we, wb_data,
    input  alu_rg3, store_data_rg3, pc_plus4_rg3, rd_rg3, RWBEn_rg3, MEMRW_rg3,
           WBSel_rg3, func_3_rg3, instt3, valid_rg3, redirect, redirect_pc
  );

  modport slave (
    input  stall, ImmOut_rg2, data_R1_rg2, data_R2_rg2, count_rg2, ALUSel_rg2,
           ASel_rg2, BSel_rg2, RWBEn_rg2, MEMRW_rg2, WBSel_rg2, func_3_rg2,
           rd_rg2, rs1_rg2, rs2_rg2, opcode_rg2, instt2, wb_rd, wb_we, wb_data,
    output alu_rg3, store_data_rg3, pc_plus4_rg3, rd_rg3, RWBEn_rg3, MEMRW_rg3,
           WBSel_rg3, func_3_rg3, instt3, valid_rg3, redirect, redirect_pc
  );
endinterface

// File: rtl/exe_alu.sv
// Combinational ALU and branch comparator for the execute stage.
module exe_alu
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] cmp_a,
  input  logic [XLEN-1:0] cmp_b,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result_c,
  output logic            br_cond_c
);

  logic [4:0] shamt;
  assign shamt = op_b[4:0];

  always_comb begin
    result_c = '0;
    case (alu_sel)
      ALU_ADD:   result_c = op_a + op_b;
      ALU_SUB:   result_c = op_a - op_b;
      ALU_SLL:   result_c = op_a << shamt;
      ALU_SLT:   result_c = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU:  result_c = XLEN'(op_a < op_b);
      ALU_XOR:   result_c = op_a ^ op_b;
      ALU_SRL:   result_c = op_a >> shamt;
      ALU_SRA:   result_c = XLEN'($signed(op_a) >>> shamt);
      ALU_OR:    result_c = op_a | op_b;
      ALU_AND:   result_c = op_a & op_b;
      ALU_PASSB: result_c = op_b;
      default:   result_c = '0;
    endcase
  end

  // 010/011 are not branch encodings and fall to the never-taken default
  always_comb begin
    br_cond_c = 1'b0;
    case (funct3)
      F3_BEQ:  br_cond_c = (cmp_a == cmp_b);
      F3_BNE:  br_cond_c = (cmp_a != cmp_b);
      F3_BLT:  br_cond_c = ($signed(cmp_a) <  $signed(cmp_b));
      F3_BGE:  br_cond_c = ($signed(cmp_a) >= $signed(cmp_b));
      F3_BLTU: br_cond_c = (cmp_a <  cmp_b);
      F3_BGEU: br_cond_c = (cmp_a >= cmp_b);
      default: br_cond_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/stage_3_exe_mem.sv
// Execute stage: operand forwarding, ALU, branch/jump redirect, and the EX/MEM pipeline register.
module stage_3_exe_mem
  import core_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic             cpu_clk,
  input  logic             reset,
  stage_3_exe_mem_if.slave bus
);

  logic [XLEN-1:0] alu_q, alu_d, sd_q, sd_d, pc4_q, pc4_d;
  logic [4:0]      rd_q, rd_d;
  logic            rwb_q, rwb_d, mrw_q, mrw_d, valid_q, valid_d;
  logic [1:0]      wbs_q, wbs_d;
  logic [2:0]      f3_q, f3_d;
  logic [31:0]     inst_q, inst_d;

  logic            ex_ok, ex_hit1, ex_hit2, wb_hit1, wb_hit2;
  logic [XLEN-1:0] ex_val, fwd_rs1, fwd_rs2, op_a, op_b, alu_res;
  logic            br_cond, is_br, is_jal, is_jalr, is_bubble;

  // A load sitting in EX/MEM (WB_MEM) never forwards; load-use is stalled upstream
  assign ex_ok   = FWD_EN && (rd_q != 5'd0) && rwb_q && (wbs_q != WB_MEM);
  assign ex_hit1 = ex_ok && (bus.rs1_rg2 == rd_q);
  assign ex_hit2 = ex_ok && (bus.rs2_rg2 == rd_q);
  assign wb_hit1 = FWD_EN && bus.wb_we && (bus.wb_rd != 5'd0) && (bus.rs1_rg2 == bus.wb_rd);
  assign wb_hit2 = FWD_EN && bus.wb_we && (bus.wb_rd != 5'd0) && (bus.rs2_rg2 == bus.wb_rd);
  assign ex_val  = (wbs_q == WB_PC4) ? pc4_q : alu_q;

  always_comb begin
    fwd_rs1 = bus.data_R1_rg2;
    fwd_rs2 = bus.data_R2_rg2;
    if (ex_hit1)      fwd_rs1 = ex_val;
    else if (wb_hit1) fwd_rs1 = bus.wb_data;
    if (ex_hit2)      fwd_rs2 = ex_val;
    else if (wb_hit2) fwd_rs2 = bus.wb_data;
  end

  assign op_a = bus.ASel_rg2 ? bus.count_rg2  : fwd_rs1;
  assign op_b = bus.BSel_rg2 ? bus.ImmOut_rg2 : fwd_rs2;

  exe_alu #(.XLEN(XLEN)) u_alu (
    .op_a      (op_a),
    .op_b      (op_b),
    .alu_sel   (bus.ALUSel_rg2),
    .cmp_a     (fwd_rs1),
    .cmp_b     (fwd_rs2),
    .funct3    (bus.func_3_rg2),
    .result_c  (alu_res),
    .br_cond_c (br_cond)
  );

  assign is_br   = (bus.opcode_rg2 == OP_BRANCH);
  assign is_jal  = (bus.opcode_rg2 == OP_JAL);
  assign is_jalr = (bus.opcode_rg2 == OP_JALR);

  assign bus.redirect    = !reset && !bus.stall && (is_jal || is_jalr || (is_br && br_cond));
  assign bus.redirect_pc = is_jalr ? {alu_res[XLEN-1:1], 1'b0} : alu_res;

  assign is_bubble = (bus.instt2 == 32'd0);

  // EX/MEM next state: hold on stall, otherwise capture; bubbles carry no side effects
  always_comb begin
    alu_d   = alu_q;
    sd_d    = sd_q;
    pc4_d   = pc4_q;
    rd_d    = rd_q;
    rwb_d   = rwb_q;
    mrw_d   = mrw_q;
    wbs_d   = wbs_q;
    f3_d    = f3_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (!bus.stall) begin
      alu_d   = alu_res;
      sd_d    = fwd_rs2;
      pc4_d   = bus.count_rg2 + XLEN'(4);
      rd_d    = bus.rd_rg2;
      rwb_d   = bus.RWBEn_rg2 && !is_bubble;
      mrw_d   = bus.MEMRW_rg2 && !is_bubble;
      wbs_d   = bus.WBSel_rg2;
      f3_d    = bus.func_3_rg2;
      inst_d  = bus.instt2;
      valid_d = !is_bubble;
    end
  end

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      alu_q   <= '0;
      sd_q    <= '0;
      pc4_q   <= '0;
      rd_q    <= '0;
      rwb_q   <= 1'b0;
      mrw_q   <= 1'b0;
      wbs_q   <= '0;
      f3_q    <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      alu_q   <= alu_d;
      sd_q    <= sd_d;
      pc4_q   <= pc4_d;
      rd_q    <= rd_d;
      rwb_q   <= rwb_d;
      mrw_q   <= mrw_d;
      wbs_q   <= wbs_d;
      f3_q    <= f3_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign bus.alu_rg3        = alu_q;
  assign bus.store_data_rg3 = sd_q;
  assign bus.pc_plus4_rg3   = pc4_q;
  assign bus.rd_rg3         = rd_q;
  assign bus.RWBEn_rg3      = rwb_q;
  assign bus.MEMRW_rg3      = mrw_q;
  assign bus.WBSel_rg3      = wbs_q;
  assign bus.func_3_rg3     = f3_q;
  assign bus.instt3         = inst_q;
  assign bus.valid_rg3      = valid_q;

endmodule

// File: tb/tb_stage_3_exe_mem.sv
// Directed vector bench for the execute stage / EX/MEM register.
module tb_stage_3_exe_mem;
  import core_pkg::*;

  logic cpu_clk = 1'b0;
  logic reset;
  always #5 cpu_clk = ~cpu_clk;

  stage_3_exe_mem_if #(.XLEN(32)) bus();

  stage_3_exe_mem #(.XLEN(32), .FWD_EN(1'b1)) dut (
    .cpu_clk (cpu_clk),
    .reset   (reset),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] imm, r1, r2, pc;
    logic [3:0]  alu;
    logic        asel, bsel, rwb, mrw;
    logic [1:0]  wbs;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2, opc;
    logic [31:0] inst;
    logic [4:0]  wbrd;
    logic        wbwe;
    logic [31:0] wbdata;
    logic [31:0] e_alu, e_sd;
    logic        e_red;
    logic [31:0] e_rpc;
    logic        e_valid;
  } vec_t;

  localparam int NV = 17;
  vec_t v [NV];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    bus.stall       = 1'b0;
    bus.ImmOut_rg2  = t.imm;
    bus.data_R1_rg2 = t.r1;
    bus.data_R2_rg2 = t.r2;
    bus.count_rg2   = t.pc;
    bus.ALUSel_rg2  = t.alu;
    bus.ASel_rg2    = t.asel;
    bus.BSel_rg2    = t.bsel;
    bus.RWBEn_rg2   = t.rwb;
    bus.MEMRW_rg2   = t.mrw;
    bus.WBSel_rg2   = t.wbs;
    bus.func_3_rg2  = t.f3;
    bus.rd_rg2      = t.rd;
    bus.rs1_rg2     = t.rs1;
    bus.rs2_rg2     = t.rs2;
    bus.opcode_rg2  = t.opc;
    bus.instt2      = t.inst;
    bus.wb_rd       = t.wbrd;
    bus.wb_we       = t.wbwe;
    bus.wb_data     = t.wbdata;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " alu"},   bus.alu_rg3, 32'h0);
    chk({tag, " sd"},    bus.store_data_rg3, 32'h0);
    chk({tag, " pc4"},   bus.pc_plus4_rg3, 32'h0);
    chk({tag, " rd"},    32'(bus.rd_rg3), 32'h0);
    chk({tag, " ctl"},   {26'd0, bus.RWBEn_rg3, bus.MEMRW_rg3, bus.WBSel_rg3, bus.valid_rg3, bus.redirect}, 32'h0);
    chk({tag, " f3"},    32'(bus.func_3_rg3), 32'h0);
    chk({tag, " inst"},  bus.instt3, 32'h0);
  endtask

  initial begin
    //        imm          r1           r2           pc         alu  as  bs  rwb mrw wbs  f3    rd  rs1 rs2 opc    inst          wbrd wbwe wbdata   e_alu        e_sd         red e_rpc        val
    v[0]  = '{32'h0,       32'd5,       32'd7,       32'h0,     4'd0,1'b0,1'b0,1'b1,1'b0,2'd1,3'd0,5'd3,5'd1,5'd2,5'h0C,32'h002081B3,5'd0,1'b0,32'h0,  32'd12,      32'd7,       1'b0,32'h0,      1'b1};
    v[1]  = '{32'h10,      32'h0,       32'h0,       32'h4,     4'd0,1'b0,1'b1,1'b1,1'b0,2'd1,3'd0,5'd5,5'd0,5'd0,5'h04,32'h01000293,5'd0,1'b0,32'h0,  32'h10,      32'h0,       1'b0,32'h0,      1'b1};
    v[2]  = '{32'h1,       32'h0,       32'h0,       32'h8,     4'd0,1'b0,1'b1,1'b1,1'b0,2'd1,3'd0,5'd6,5'd5,5'd1,5'h04,32'h00128313,5'd0,1'b0,32'h0,  32'h11,      32'h0,       1'b0,32'h0,      1'b1};
    v[3]  = '{32'h55,      32'h0,       32'h0,       32'hC,     4'd0,1'b0,1'b1,1'b1,1'b0,2'd1,3'd0,5'd0,5'd0,5'd0,5'h04,32'h05500013,5'd0,1'b0,32'h0,  32'h55,      32'h0,       1'b0,32'h0,      1'b1};
    v[4]  = '{32'h1,       32'h0,       32'h0,       32'h10,    4'd0,1'b0,1'b1,1'b1,1'b0,2'd1,3'd0,5'd7,5'd0,5'd0,5'h04,32'h00100393,5'd0,1'b0,32'h0,  32'h1,       32'h0,       1'b0,32'h0,      1'b1};
    v[5]  = '{32'hAA,      32'h0,       32'h0,       32'h14,    4'd0,1'b0,1'b1,1'b1,1'b0,2'd1,3'd0,5'd6,5'd0,5'd0,5'h04,32'h0AA00313,5'd0,1'b0,32'h0,  32'hAA,      32'h0,       1'b0,32'h0,      1'b1};
    v[6]  = '{32'h8,       32'h0,       32'h0,       32'h18,    4'd0,1'b0,1'b1,1'b0,1'b1,2'd0,3'd2,5'd0,5'd0,5'd6,5'h08,32'h00602423,5'd6,1'b1,32'hBB, 32'h8,       32'hAA,      1'b0,32'h0,      1'b1};
    v[7]  = '{32'hC,       32'h0,       32'h0,       32'h1C,    4'd0,1'b0,1'b1,1'b0,1'b1,2'd0,3'd2,5'd0,5'd0,5'd6,5'h08,32'h00602623,5'd6,1'b1,32'hBB, 32'hC,       32'hBB,      1'b0,32'h0,      1'b1};
    v[8]  = '{32'h20,      32'h33,      32'h33,      32'h100,   4'd0,1'b1,1'b1,1'b0,1'b0,2'd0,3'd0,5'd0,5'd1,5'd2,5'h18,32'h02208063,5'd0,1'b0,32'h0,  32'h120,     32'h33,      1'b1,32'h120,    1'b1};
    v[9]  = '{32'h20,      32'h33,      32'h33,      32'h104,   4'd0,1'b1,1'b1,1'b0,1'b0,2'd0,3'd1,5'd0,5'd1,5'd2,5'h18,32'h02209063,5'd0,1'b0,32'h0,  32'h124,     32'h33,      1'b0,32'h0,      1'b1};
    v[10] = '{32'hFFFFFFF8,32'hFFFFFFFF,32'h1,       32'h200,   4'd0,1'b1,1'b1,1'b0,1'b0,2'd0,3'd4,5'd0,5'd1,5'd2,5'h18,32'hFE20CCE3,5'd0,1'b0,32'h0,  32'h1F8,     32'h1,       1'b1,32'h1F8,    1'b1};
    v[11] = '{32'hFFFFFFF8,32'hFFFFFFFF,32'h1,       32'h204,   4'd0,1'b1,1'b1,1'b0,1'b0,2'd0,3'd6,5'd0,5'd1,5'd2,5'h18,32'hFE20ECE3,5'd0,1'b0,32'h0,  32'h1FC,     32'h1,       1'b0,32'h0,      1'b1};
    v[12] = '{32'h0,       32'h203,     32'h0,       32'h300,   4'd0,1'b0,1'b1,1'b1,1'b0,2'd2,3'd0,5'd1,5'd10,5'd0,5'h19,32'h000500E7,5'd0,1'b0,32'h0, 32'h203,     32'h0,       1'b1,32'h202,    1'b1};
    v[13] = '{32'h0,       32'h0,       32'h0,       32'h202,   4'd0,1'b0,1'b1,1'b1,1'b0,2'd1,3'd0,5'd9,5'd1,5'd0,5'h04,32'h00008493,5'd0,1'b0,32'h0,  32'h304,     32'h0,       1'b0,32'h0,      1'b1};
    v[14] = '{32'h404,     32'h80000000,32'h0,       32'h206,   4'd7,1'b0,1'b1,1'b1,1'b0,2'd1,3'd5,5'd12,5'd11,5'd4,5'h04,32'h4045D613,5'd0,1'b0,32'h0,32'hF8000000,32'h0,       1'b0,32'h0,      1'b1};
    v[15] = '{32'h0,       32'h0,       32'h1,       32'h20A,   4'd1,1'b0,1'b0,1'b1,1'b0,2'd1,3'd0,5'd8,5'd12,5'd13,5'h0C,32'h40D60433,5'd0,1'b0,32'h0,32'hF7FFFFFF,32'h1,       1'b0,32'h0,      1'b1};
    v[16] = '{32'h0,       32'h1,       32'h2,       32'h0,     4'd0,1'b0,1'b0,1'b1,1'b1,2'd1,3'd0,5'd0,5'd0,5'd0,5'h00,32'h0,       5'd0,1'b0,32'h0,  32'h3,       32'h2,       1'b0,32'h0,      1'b0};

    reset = 1'b1;
    drive(v[16]);
    #2;
    chk_zero("reset");
    @(negedge cpu_clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge cpu_clk);
      drive(v[i]);
      #1;
      chk($sformatf("v%0d redirect", i), 32'(bus.redirect), 32'(v[i].e_red));
      if (v[i].e_red) chk($sformatf("v%0d redirect_pc", i), bus.redirect_pc, v[i].e_rpc);
      @(posedge cpu_clk);
      #1;
      chk($sformatf("v%0d alu", i),   bus.alu_rg3, v[i].e_alu);
      chk($sformatf("v%0d sd", i),    bus.store_data_rg3, v[i].e_sd);
      chk($sformatf("v%0d pc4", i),   bus.pc_plus4_rg3, v[i].pc + 32'd4);
      chk($sformatf("v%0d rd", i),    32'(bus.rd_rg3), 32'(v[i].rd));
      chk($sformatf("v%0d valid", i), 32'(bus.valid_rg3), 32'(v[i].e_valid));
      chk($sformatf("v%0d rwb", i),   32'(bus.RWBEn_rg3), 32'(v[i].rwb & v[i].e_valid));
      chk($sformatf("v%0d mrw", i),   32'(bus.MEMRW_rg3), 32'(v[i].mrw & v[i].e_valid));
      chk($sformatf("v%0d wbs", i),   32'(bus.WBSel_rg3), 32'(v[i].wbs));
      chk($sformatf("v%0d f3", i),    32'(bus.func_3_rg3), 32'(v[i].f3));
      chk($sformatf("v%0d inst", i),  bus.instt3, v[i].inst);
    end

    // Taken BEQ presented while stalled: no redirect, register holds the bubble
    @(negedge cpu_clk);
    drive(v[8]);
    bus.stall = 1'b1;
    #1;
    chk("stall redirect", 32'(bus.redirect), 32'h0);
    @(posedge cpu_clk);
    #1;
    chk("stall hold alu",   bus.alu_rg3, 32'h3);
    chk("stall hold sd",    bus.store_data_rg3, 32'h2);
    chk("stall hold pc4",   bus.pc_plus4_rg3, 32'h4);
    chk("stall hold valid", 32'(bus.valid_rg3), 32'h0);
    chk("stall hold inst",  bus.instt3, 32'h0);

    @(negedge cpu_clk);
    bus.stall = 1'b0;
    #1;
    chk("unstall redirect",    32'(bus.redirect), 32'h1);
    chk("unstall redirect_pc", bus.redirect_pc, 32'h120);
    @(posedge cpu_clk);
    #1;
    chk("unstall alu",   bus.alu_rg3, 32'h120);
    chk("unstall valid", 32'(bus.valid_rg3), 32'h1);

    // Asynchronous reset between clock edges, taken branch still on the inputs
    #2;
    reset = 1'b1;
    #1;
    chk_zero("midreset");
    @(negedge cpu_clk);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stage_3_exe_mem.md
Name: stage_3_exe_mem

Overview:
Execute stage plus EX/MEM pipeline register of the 5-stage RV32I core. It consumes the decode/execute register outputs and resolves operand forwarding, the ALU operation, branch/jump conditions and the redirect target. Results are registered into the EX/MEM register, which feeds the memory stage and the tracer (instt3).

Parameters:
XLEN, 32, datapath width
FWD_EN, 1, 1 = forwarding muxes active; 0 = register-file operands used directly

Ports:
cpu_clk  in  1  clock
reset  in  1  asynchronous, active-high
stall  in  1  memory-stage stall; hold EX/MEM register
ImmOut_rg2  in  32  immediate
data_R1_rg2  in  32  rs1 register-file data
data_R2_rg2  in  32  rs2 register-file data
count_rg2  in  32  instruction PC
ALUSel_rg2  in  4  ALU op (package enum)
ASel_rg2  in  1  0 = rs1, 1 = PC
BSel_rg2  in  1  0 = rs2, 1 = imm
RWBEn_rg2  in  1  register write enable
MEMRW_rg2  in  1  1 = store
WBSel_rg2  in  2  0 = mem, 1 = alu, 2 = pc+4
func_3_rg2  in  3  funct3
rd_rg2, rs1_rg2, rs2_rg2  in  5 each  register indices
opcode_rg2  in  5  inst[6:2]
instt2  in  32  raw instruction (tracer)
wb_rd  in  5  WB destination
wb_we  in  1  WB write enable
wb_data  in  32  WB result
alu_rg3  out  32  registered ALU result / address
store_data_rg3  out  32  forwarded rs2
pc_plus4_rg3  out  32  count_rg2+4
rd_rg3  out  5  destination
RWBEn_rg3, MEMRW_rg3  out  1 each  controls
WBSel_rg3  out  2  writeback select
func_3_rg3  out  3  funct3
instt3  out  32  instruction
valid_rg3  out  1  slot holds a real instruction
redirect  out  1  taken branch/jump (combinational)
redirect_pc  out  32  target (combinational)

Behaviour:
- Reset: all *_rg3 outputs are 0; redirect is 0 while reset is high.
- Forwarding per source (rs1, rs2), priority order:
  - EX/MEM hit: rsX == rd_rg3, rd_rg3 != 0, RWBEn_rg3 = 1, WBSel_rg3 != 0 → use alu_rg3; if WBSel_rg3 = 2 → use pc_plus4_rg3.
  - Else WB hit: rsX == wb_rd, wb_rd != 0, wb_we = 1 → use wb_data.
  - Else use register-file data.
  - Load-use hazards are stalled upstream; the EX/MEM load-result case is never forwarded.
- ALU operand selection: A = ASel ? count_rg2 : fwd_rs1; B = BSel ? ImmOut_rg2 : fwd_rs2.
- ALU ops: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10. Unused codes give 0. Shift amount is B[4:0]. All arithmetic wraps at 32 bits.
- Branch compare on forwarded rs1/rs2 per funct3: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111. Funct3 010/011 never taken.
- redirect = !stall & (JAL | JALR | (BRANCH & cond)).
  - Opcodes: BRANCH 11000, JAL 11011, JALR 11001.
  - redirect_pc = ALU result; for JALR, bit 0 is cleared.
  - Decode sets ASel = 1, BSel = 1, ALU = ADD for branch/jump.
- EX/MEM register, each cpu_clk rising edge:
  - stall = 1: hold all *_rg3 outputs.
  - stall = 0: load computed values.
  - valid_rg3 = (instt2 != 0). A bubble (instt2 = 0) loads RWBEn_rg3 = 0, MEMRW_rg3 = 0, valid_rg3 = 0.
- Latency: 1 cycle from the ID/EX register to the EX/MEM register; redirect has 0 latency.
- Forwarding compares against the held rd_rg3 while stalled.
- Reset asserted mid-operation clears the register immediately (asynchronous).

Decomposition:
- Package core_pkg holds:
  - alu_op_e
  - opcode constants (OP_BRANCH, OP_JAL, OP_JALR)
  - WBSel constants (WB_MEM, WB_ALU, WB_PC4)
  - branch funct3 constants
- One sub-module, exe_alu: combinational ALU plus branch comparator.

Test Plan:
- ADD x3 = x1 + x2 with data_R1 = 5, data_R2 = 7, no hazards → alu_rg3 = 12, rd_rg3 = 3, valid_rg3 = 1 one cycle later.
- Back-to-back dependency: previous ALU writes x5 = 0x10 (in EX/MEM), current rs1 = 5, data_R1 = 0 (stale), ADDI imm 1 → alu_rg3 = 0x11. Same case with x0 as rd → no forwarding.
- Priority: both EX/MEM (0xAA) and WB (0xBB) target rs2 = 6 → store_data_rg3 = 0xAA.
- BEQ at PC 0x100 with equal operands, imm 0x20 → redirect = 1, redirect_pc = 0x120. Same instruction with stall = 1 → redirect = 0 and outputs held.
- JALR with rs1 = 0x203, imm 0 → redirect_pc = 0x202, pc_plus4_rg3 = count_rg2 + 4. SRA with 0x80000000 >> 4 → 0xF8000000.
- Reset asserted mid-stream → all outputs 0 before the next clock edge; bubble (instt2 = 0) → valid_rg3 = 0, RWBEn_rg3 = 0.
